// File: rtl/pista_pkg.sv
// Shared definitions for the track transmitter and its checker: default track,
// digit width, 3-bit state encoding and the fault-injection digit rule.
package pista_pkg;

  localparam logic [23:0] PISTA_PADRAO   = 24'h590060;
  localparam int          LARGURA_DIGITO = 4;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    EMITE     = 3'd1,
    ESPERA    = 3'd2,
    CONCLUIDO = 3'd3
  } estado_t;

  // (d+1) mod 10; a non-BCD nibble collapses to 0 so the output stays valid BCD.
  function automatic logic [LARGURA_DIGITO-1:0] digito_corrompido(
    input logic [LARGURA_DIGITO-1:0] d
  );
    if (d >= 4'd9) return '0;
    return d + 4'd1;
  endfunction

endpackage

// File: rtl/emissor_pista_if.sv
// Digit-stream bus between a start/fault controller (master) and the track
// transmitter (slave).
interface emissor_pista_if;

  logic                                 iniciar;
  logic                                 injeta_erro;
  logic [2:0]                           pos_erro;
  logic [pista_pkg::LARGURA_DIGITO-1:0] numero;
  logic                                 insere;
  logic                                 ocupado;
  logic                                 concluido;

  modport master (
    output iniciar, injeta_erro, pos_erro,
    input  numero, insere, ocupado, concluido
  );

  modport slave (
    input  iniciar, injeta_erro, pos_erro,
    output numero, insere, ocupado, concluido
  );

endinterface

// File: rtl/temporizador_intervalo.sv
// Loadable down-counter that paces the gap between strobes: loaded with
// INTERVALO-1 on carrega, fim marks the final gap cycle.
module temporizador_intervalo #(
  parameter int INTERVALO = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic carrega,
  output logic fim
);

  localparam int W = $clog2(INTERVALO) + 1;

  logic [W-1:0] cont_q, cont_d;

  always_comb begin
    // NOTE: default assignment first so every path drives cont_d and no latch is inferred.
    cont_d = cont_q;
    if (carrega) begin
      cont_d = W'(INTERVALO - 1);
    end else if (cont_q != '0) begin
      cont_d = cont_q - W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign fim = (cont_q == W'(1));

endmodule

// File: rtl/emissor_pista.sv
// Track-sequence transmitter: plays PISTA one digit per insere strobe, spaced
// INTERVALO cycles, with optional corruption of one chosen digit.
module emissor_pista
  import pista_pkg::*;
#(
  parameter int                                     NUM_DIGITOS = 6,
  parameter logic [LARGURA_DIGITO*NUM_DIGITOS-1:0]  PISTA       = PISTA_PADRAO,
  parameter int                                     INTERVALO   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  emissor_pista_if.slave       bus
);

  estado_t                   estado_q, estado_d;
  logic [2:0]                pos_q, pos_d;
  logic                      injeta_q, injeta_d;
  logic [2:0]                pos_erro_q, pos_erro_d;
  logic [LARGURA_DIGITO-1:0] numero_q, numero_d;
  logic                      insere_q, insere_d;
  logic                      ocupado_q, ocupado_d;
  logic                      concluido_q, concluido_d;

  logic                      carrega;
  logic                      fim_espera;
  logic                      ultimo;
  logic                      corrompe;
  logic [LARGURA_DIGITO-1:0] digito_atual;
  logic [LARGURA_DIGITO-1:0] digitos [8];

  // Slot 0 is the most-significant nibble; unused slots read as 0.
  for (genvar i = 0; i < 8; i++) begin : g_dig
    if (i < NUM_DIGITOS) begin : g_val
      assign digitos[i] = PISTA[LARGURA_DIGITO*(NUM_DIGITOS-1-i) +: LARGURA_DIGITO];
    end else begin : g_zero
      assign digitos[i] = '0;
    end
  end

  temporizador_intervalo #(
    .INTERVALO (INTERVALO)
  ) u_temporizador (
    .clk     (clk),
    .reset   (reset),
    .carrega (carrega),
    .fim     (fim_espera)
  );

  assign ultimo       = (pos_q == 3'(NUM_DIGITOS - 1));
  assign corrompe     = injeta_q && (pos_q == pos_erro_q);
  assign digito_atual = corrompe ? digito_corrompido(digitos[pos_q]) : digitos[pos_q];

  always_comb begin
    estado_d   = estado_q;
    pos_d      = pos_q;
    injeta_d   = injeta_q;
    pos_erro_d = pos_erro_q;
    carrega    = 1'b0;

    unique case (estado_q)
      OCIOSO, CONCLUIDO: begin
        if (bus.iniciar) begin
          estado_d   = EMITE;
          pos_d      = '0;
          injeta_d   = bus.injeta_erro;
          pos_erro_d = bus.pos_erro;
        end
      end
      EMITE: begin
        carrega = 1'b1;
        if (ultimo) begin
          estado_d = CONCLUIDO;
        end else begin
          pos_d    = pos_q + 3'd1;
          estado_d = (INTERVALO > 1) ? ESPERA : EMITE;
        end
      end
      ESPERA: begin
        if (fim_espera) estado_d = EMITE;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Outputs are registered from the current state, so they trail it by one cycle.
  always_comb begin
    insere_d    = (estado_q == EMITE);
    numero_d    = insere_d ? digito_atual : numero_q;
    ocupado_d   = (estado_q == EMITE) || (estado_q == ESPERA);
    concluido_d = (estado_q == CONCLUIDO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      pos_q       <= '0;
      injeta_q    <= 1'b0;
      pos_erro_q  <= '0;
      numero_q    <= '0;
      insere_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      pos_q       <= pos_d;
      injeta_q    <= injeta_d;
      pos_erro_q  <= pos_erro_d;
      numero_q    <= numero_d;
      insere_q    <= insere_d;
      ocupado_q   <= ocupado_d;
      concluido_q <= concluido_d;
    end
  end

  assign bus.numero    = numero_q;
  assign bus.insere    = insere_q;
  assign bus.ocupado   = ocupado_q;
  assign bus.concluido = concluido_q;

endmodule

// File: tb/tb_emissor_pista.sv
// Directed bench for emissor_pista: default track, fault injection, held start,
// resets, back-to-back strobes and a short non-BCD track.
module tb_emissor_pista;

  logic       clk;
  logic       reset;
  logic       iniciar;
  logic       injeta_erro;
  logic [2:0] pos_erro;
  int         sel;

  emissor_pista_if bus_a ();
  emissor_pista_if bus_b ();
  emissor_pista_if bus_c ();

  emissor_pista #(.NUM_DIGITOS(6), .PISTA(24'h590060), .INTERVALO(4))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  emissor_pista #(.NUM_DIGITOS(6), .PISTA(24'h590060), .INTERVALO(1))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  emissor_pista #(.NUM_DIGITOS(2), .PISTA(8'hB9), .INTERVALO(2))
    dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  assign bus_a.iniciar     = iniciar && (sel == 0);
  assign bus_b.iniciar     = iniciar && (sel == 1);
  assign bus_c.iniciar     = iniciar && (sel == 2);
  assign bus_a.injeta_erro = injeta_erro;
  assign bus_b.injeta_erro = injeta_erro;
  assign bus_c.injeta_erro = injeta_erro;
  assign bus_a.pos_erro    = pos_erro;
  assign bus_b.pos_erro    = pos_erro;
  assign bus_c.pos_erro    = pos_erro;

  logic [3:0] obs_numero;
  logic       obs_insere, obs_ocupado, obs_concluido;

  always_comb begin
    obs_numero    = bus_a.numero;
    obs_insere    = bus_a.insere;
    obs_ocupado   = bus_a.ocupado;
    obs_concluido = bus_a.concluido;
    case (sel)
      1: begin
        obs_numero    = bus_b.numero;
        obs_insere    = bus_b.insere;
        obs_ocupado   = bus_b.ocupado;
        obs_concluido = bus_b.concluido;
      end
      2: begin
        obs_numero    = bus_c.numero;
        obs_insere    = bus_c.insere;
        obs_ocupado   = bus_c.ocupado;
        obs_concluido = bus_c.concluido;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] dig [16];
  int         t_str [16];
  int         n_str, t_conc, n_ocup, t_ocup_ini, t_ocup_fim;
  logic [3:0] num_t2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_saidas_zero(input string tag);
    check($sformatf("%s numero", tag),    32'(obs_numero),    32'd0);
    check($sformatf("%s insere", tag),    32'(obs_insere),    32'd0);
    check($sformatf("%s ocupado", tag),   32'(obs_ocupado),   32'd0);
    check($sformatf("%s concluido", tag), 32'(obs_concluido), 32'd0);
  endtask

  // t=0 is the first falling edge after the edge that sampled iniciar.
  task automatic observa(input int ciclos);
    logic prev_conc;
    prev_conc  = 1'b1;
    n_str      = 0;
    t_conc     = -1;
    n_ocup     = 0;
    t_ocup_ini = -1;
    t_ocup_fim = -1;
    num_t2     = '0;
    for (int i = 0; i < 16; i++) begin
      dig[i]   = '0;
      t_str[i] = -1000;
    end
    for (int t = 0; t < ciclos; t++) begin
      if (obs_insere) begin
        if (n_str < 16) begin
          dig[n_str]   = obs_numero;
          t_str[n_str] = t;
        end
        n_str++;
      end
      if (obs_ocupado) begin
        n_ocup++;
        if (t_ocup_ini < 0) t_ocup_ini = t;
        t_ocup_fim = t;
      end
      if (obs_concluido && !prev_conc && t_conc < 0) t_conc = t;
      prev_conc = obs_concluido;
      if (t == 2) num_t2 = obs_numero;
      @(negedge clk);
    end
  endtask

  task automatic pulso();
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
  endtask

  task automatic verifica_seq(input string tag, input int n, input logic [31:0] seq);
    check($sformatf("%s n_strobes", tag), 32'(n_str), 32'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s digito%0d", tag, i), 32'(dig[i]), 32'(seq[4*(n-1-i) +: 4]));
    end
  endtask

  task automatic verifica_tempo(input string tag, input int n, input int intervalo);
    check($sformatf("%s primeiro strobe", tag), 32'(t_str[0]), 32'd1);
    for (int i = 1; i < n; i++) begin
      check($sformatf("%s espaco%0d", tag, i), 32'(t_str[i] - t_str[i-1]), 32'(intervalo));
    end
    check($sformatf("%s concluido", tag),   32'(t_conc),     32'((n-1)*intervalo + 2));
    check($sformatf("%s ocupado ciclos", tag), 32'(n_ocup),  32'((n-1)*intervalo + 1));
    check($sformatf("%s ocupado inicio", tag), 32'(t_ocup_ini), 32'd1);
    check($sformatf("%s ocupado fim", tag), 32'(t_ocup_fim), 32'((n-1)*intervalo + 1));
  endtask

  initial begin
    reset       = 1'b1;
    iniciar     = 1'b0;
    injeta_erro = 1'b0;
    pos_erro    = '0;
    sel         = 0;
    @(negedge clk);
    @(negedge clk);
    check_saidas_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Default run on A.
    pulso();
    observa(30);
    verifica_seq("A padrao", 6, 32'h590060);
    verifica_tempo("A padrao", 6, 4);
    check("A numero retido", 32'(num_t2), 32'd5);
    check("A concluido retido", 32'(obs_concluido), 32'd1);
    check("A ocupado apos fim", 32'(obs_ocupado), 32'd0);

    // Fault at digit 1, restarted straight from CONCLUIDO; settings change right after capture.
    injeta_erro = 1'b1;
    pos_erro    = 3'd1;
    iniciar     = 1'b1;
    @(negedge clk);
    iniciar     = 1'b0;
    injeta_erro = 1'b0;
    pos_erro    = 3'd0;
    observa(30);
    verifica_seq("A erro pos1", 6, 32'h500060);
    check("A erro pos1 concluido", 32'(t_conc), 32'd22);

    injeta_erro = 1'b1;
    pos_erro    = 3'd5;
    pulso();
    observa(30);
    verifica_seq("A erro pos5", 6, 32'h590061);

    pos_erro = 3'd6;
    pulso();
    observa(30);
    verifica_seq("A erro pos6", 6, 32'h590060);

    pos_erro = 3'd7;
    pulso();
    observa(30);
    verifica_seq("A erro pos7", 6, 32'h590060);
    injeta_erro = 1'b0;
    pos_erro    = 3'd0;

    // iniciar held high: one full run, then the next starts right after concluido.
    iniciar = 1'b1;
    @(negedge clk);
    observa(40);
    iniciar = 1'b0;
    check("A mantido strobes", 32'(n_str), 32'd11);
    check("A mantido ultimo run1", 32'(t_str[5]), 32'd21);
    check("A mantido concluido", 32'(t_conc), 32'd22);
    check("A mantido run2 inicio", 32'(t_str[6]), 32'd23);
    check("A mantido run2 digito", 32'(dig[6]), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Reset after the third strobe, then a clean replay.
    pulso();
    observa(10);
    check("A meio strobes", 32'(n_str), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_saidas_zero("A reset meio");
    pulso();
    observa(30);
    verifica_seq("A apos reset", 6, 32'h590060);
    check("A apos reset inicio", 32'(t_str[0]), 32'd1);

    // Reset and iniciar together: reset wins.
    reset   = 1'b1;
    iniciar = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    iniciar = 1'b0;
    observa(6);
    check("A reset+iniciar strobes", 32'(n_str), 32'd0);
    check("A reset+iniciar ocupado", 32'(n_ocup), 32'd0);

    // Back-to-back strobes on B.
    sel = 1;
    pulso();
    observa(12);
    verifica_seq("B", 6, 32'h590060);
    verifica_tempo("B", 6, 1);

    // Two-digit track with a non-BCD nibble on C.
    sel = 2;
    pulso();
    observa(8);
    verifica_seq("C", 2, 32'hB9);
    verifica_tempo("C", 2, 2);

    injeta_erro = 1'b1;
    pos_erro    = 3'd0;
    pulso();
    observa(8);
    verifica_seq("C erro pos0", 2, 32'h09);

    pos_erro = 3'd1;
    pulso();
    observa(8);
    verifica_seq("C erro pos1", 2, 32'hB0);
    injeta_erro = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
